// File: rtl/int_regfile_commit_if.sv
// Commit, dispatch and read-port signals of the integer register file.
// The register file sits on the slave end; the pipeline drives the master end.
interface int_regfile_commit_if #(
    parameter int XLEN = 64
);
    logic            commit_valid_i;
    logic            commit_wren_i;
    logic [XLEN-1:0] commit_data_i;
    logic [4:0]      commit_rdindex_i;
    logic [4:0]      rs1index_i;
    logic [4:0]      rs2index_i;
    logic [XLEN-1:0] rs1data_o;
    logic [XLEN-1:0] rs2data_o;
    logic            disp_valid_i;
    logic            disp_wren_i;
    logic [4:0]      disp_rdindex_i;
    logic            disp_ready_o;
    logic            rs1busy_o;
    logic            rs2busy_o;
    logic            flush_i;

    modport slave (
        input  commit_valid_i, commit_wren_i, commit_data_i, commit_rdindex_i,
        input  rs1index_i, rs2index_i,
        input  disp_valid_i, disp_wren_i, disp_rdindex_i, flush_i,
        output rs1data_o, rs2data_o, disp_ready_o, rs1busy_o, rs2busy_o
    );

    modport master (
        output commit_valid_i, commit_wren_i, commit_data_i, commit_rdindex_i,
        output rs1index_i, rs2index_i,
        output disp_valid_i, disp_wren_i, disp_rdindex_i, flush_i,
        input  rs1data_o, rs2data_o, disp_ready_o, rs1busy_o, rs2busy_o
    );
endinterface

// File: rtl/int_regfile_commit.sv
// Integer register file x1..x31 with commit-time writes, optional commit-to-read
// forwarding and a per-register pending-write counter for scoreboarding.
module int_regfile_commit #(
    parameter int XLEN   = 64,
    parameter int BYPASS = 1
) (
    input logic                   clk_i,
    input logic                   arst_i,
    int_regfile_commit_if.slave   rf
);
    logic [XLEN-1:0] regs_q [32];
    logic [2:0]      cnt_q  [32];

    logic        commit_we;
    logic        commit_dec;
    logic        disp_dec_hit;
    logic        disp_ready;
    logic        disp_accept;
    logic [31:1] acc_vec;
    logic [31:1] dec_vec;

    // Commits seen while reset is held are dropped, so forwarding is gated too.
    always_comb begin
        commit_we    = rf.commit_valid_i & rf.commit_wren_i &
                       (rf.commit_rdindex_i != 5'd0) & ~arst_i;
        commit_dec   = commit_we & (cnt_q[rf.commit_rdindex_i] != 3'd0);
        disp_dec_hit = commit_dec & (rf.commit_rdindex_i == rf.disp_rdindex_i);
        disp_ready   = ~(rf.disp_valid_i & rf.disp_wren_i &
                         (rf.disp_rdindex_i != 5'd0) &
                         (cnt_q[rf.disp_rdindex_i] == 3'd7) & ~disp_dec_hit);
        disp_accept  = rf.disp_valid_i & disp_ready & rf.disp_wren_i &
                       (rf.disp_rdindex_i != 5'd0) & ~rf.flush_i;
        acc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < 32; i++) begin
            acc_vec[i] = disp_accept & (rf.disp_rdindex_i == 5'(i));
            dec_vec[i] = commit_dec & (rf.commit_rdindex_i == 5'(i));
        end
    end

    always_comb begin
        rf.rs1data_o = regs_q[rf.rs1index_i];
        rf.rs2data_o = regs_q[rf.rs2index_i];
        if (rf.rs1index_i == 5'd0)
            rf.rs1data_o = '0;
        else if (BYPASS == 1 && commit_we && rf.rs1index_i == rf.commit_rdindex_i)
            rf.rs1data_o = rf.commit_data_i;
        if (rf.rs2index_i == 5'd0)
            rf.rs2data_o = '0;
        else if (BYPASS == 1 && commit_we && rf.rs2index_i == rf.commit_rdindex_i)
            rf.rs2data_o = rf.commit_data_i;
    end

    // A register whose last pending write retires this cycle is already free.
    always_comb begin
        rf.rs1busy_o = (rf.rs1index_i != 5'd0) & (cnt_q[rf.rs1index_i] != 3'd0) &
                       ~(commit_dec & (rf.commit_rdindex_i == rf.rs1index_i) &
                         (cnt_q[rf.rs1index_i] == 3'd1));
        rf.rs2busy_o = (rf.rs2index_i != 5'd0) & (cnt_q[rf.rs2index_i] != 3'd0) &
                       ~(commit_dec & (rf.commit_rdindex_i == rf.rs2index_i) &
                         (cnt_q[rf.rs2index_i] == 3'd1));
        rf.disp_ready_o = disp_ready;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            if (commit_we)
                regs_q[rf.commit_rdindex_i] <= rf.commit_data_i;
            for (int i = 1; i < 32; i++) begin
                if (rf.flush_i)
                    cnt_q[i] <= 3'd0;
                else if (acc_vec[i] && !dec_vec[i])
                    cnt_q[i] <= cnt_q[i] + 3'd1;
                else if (dec_vec[i] && !acc_vec[i])
                    cnt_q[i] <= cnt_q[i] - 3'd1;
            end
        end
    end
endmodule

// File: doc/int_regfile_commit.md
INT_REGFILE_COMMIT -- requirements
Module: int_regfile_commit

Interface
REQ-001 Parameter XLEN, default 64, integer register and commit data width.
REQ-002 Parameter BYPASS, default 1, 1 = same-cycle commit-to-read forwarding, 0 = none.
REQ-003 clk_i  in  1  single clock, all state on its rising edge.
REQ-004 arst_i  in  1  reset, asynchronous and active-high.
REQ-005 commit_valid_i  in  1  commit valid; slave end of the integer commit interface.
REQ-006 commit_wren_i  in  1  commit carries a register write.
REQ-007 commit_data_i  in  XLEN  commit write data.
REQ-008 commit_rdindex_i  in  5  commit destination register index.
REQ-009 rs1index_i, rs2index_i  in  5 each  read-port register indices.
REQ-010 rs1data_o, rs2data_o  out  XLEN each  read-port data, combinational.
REQ-011 disp_valid_i  in  1  dispatch of an instruction that will later commit.
REQ-012 disp_wren_i  in  1  dispatched instruction writes a register.
REQ-013 disp_rdindex_i  in  5  dispatched instruction destination index.
REQ-014 disp_ready_o  out  1  dispatch can be accepted this cycle.
REQ-015 rs1busy_o, rs2busy_o  out  1 each  source register has a write pending.
REQ-016 flush_i  in  1  pipeline flush, discards all pending-write tracking.

Function
REQ-017 State: 31 XLEN-bit registers x1..x31; x0 is not stored and always reads 0.
REQ-018 State: one 3-bit pending counter per register x1..x31.
REQ-019 Commit write = commit_valid_i & commit_wren_i & (commit_rdindex_i != 0); it updates the register at the next rising edge.
REQ-020 If commit_wren_i=0 or commit_rdindex_i=0, a commit write is ignored, and it never changes a register.
REQ-021 rsNdata_o = 0 when its index is 0.
REQ-022 rsNdata_o = commit_data_i when BYPASS=1, a commit write is active and its index matches.
REQ-023 In all other cases, rsNdata_o = the stored register value.
REQ-024 Dispatch accept = disp_valid_i & disp_ready_o & disp_wren_i & (disp_rdindex_i != 0) & !flush_i.
REQ-025 disp_ready_o = 0 only when disp_valid_i & disp_wren_i, disp_rdindex_i != 0, and that counter = 7 with no decrementing commit to the same index this cycle; otherwise 1.
REQ-026 Decrement = commit_valid_i & commit_wren_i & (commit_rdindex_i != 0) & (counter > 0).
REQ-027 Counter update: accept only -> +1; decrement only -> -1; both on the same index -> unchanged.
REQ-028 A commit to an index whose counter is 0 writes data but leaves the counter at 0 (no underflow).
REQ-029 flush_i=1 -> all counters become 0 at the next edge; dispatch is ignored in the same cycle.
REQ-030 A commit in a flush cycle still writes register data.
REQ-031 rsNbusy_o = 0 for index 0.
REQ-032 Otherwise rsNbusy_o = (counter != 0) & !(a decrement targets the same index with counter = 1), combinational.
REQ-033 Busy ignores a same-cycle dispatch; a new dispatch shows as busy from the next cycle.

Reset
REQ-034 arst_i=1 immediately clears all registers and counters to 0, regardless of clk_i.
REQ-035 During reset, all outputs show values derived from the zeroed state: data 0, busy 0, disp_ready_o 1.
REQ-036 A commit or dispatch coincident with reset assertion is lost.
REQ-037 Normal operation resumes at the first rising edge after arst_i deasserts.

Verification
REQ-038 Reset, commit x5=0xDEAD_BEEF, next cycle read rs1=5 -> rs1data_o=0xDEADBEEF; read x0 -> 0.
REQ-039 Commit x0=0x1234 with wren=1 -> subsequent read of x0 = 0; with commit_wren_i=0 on x3 -> x3 unchanged.
REQ-040 BYPASS=1: commit x7=0xAA while rs2index_i=7 -> same-cycle rs2data_o=0xAA; with BYPASS=0 -> old value.
REQ-041 Dispatch x9 seven times -> disp_ready_o=0 for an 8th x9 dispatch; commit x9 in the same cycle -> ready=1, counter stays 7.
REQ-042 Dispatch x4 once, then commit x4 -> rs1busy_o (rs1=4) is 1 after dispatch and 0 in the commit cycle; counter = 0 after.
REQ-043 Counters x2=3 and x6=1, assert flush_i with dispatch x2 -> all busy = 0 next cycle; register data retained.
